// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial input, tick enable and byte handshake bundle for uart_rx
interface uart_rx_if;
    logic       tick;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       bussy;
    logic       frame_err;
    logic       overrun;

    modport slave (
        input  tick, rx, ready,
        output data, valid, bussy, frame_err, overrun
    );

    modport master (
        output tick, rx, ready,
        input  data, valid, bussy, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver, 8 data bits LSB first, 1 stop bit
// UART_RX_PARITY_EN adds one even-parity bit after bit 7.
module uart_rx #(
    parameter int OVS = 16
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);
    localparam int CW = $clog2(OVS);
    localparam logic [CW-1:0] C_S0   = CW'(OVS / 2 - 2);
    localparam logic [CW-1:0] C_S1   = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] C_DEC  = CW'(OVS / 2);
    localparam logic [CW-1:0] C_LAST = CW'(OVS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK_WAIT} state_t;
`endif

    state_t        r_state, w_state_nx;
    logic          r_rx_meta, r_rx_s;
    logic [CW-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
    logic [2:0]    r_bit, w_bit_nx;
    logic [7:0]    r_shift, w_shift_nx;
    logic          r_s0, r_s1, w_s0_nx, w_s1_nx;
    logic          w_maj, w_dec, w_last;
    logic          w_good, w_ferr, w_par_bad;
    logic [7:0]    r_data;
    logic          r_valid, r_overrun, r_frame_err;

`ifdef UART_RX_PARITY_EN
    logic r_par_bad, w_par_bad_nx;
    assign w_par_bad = r_par_bad;
`else
    assign w_par_bad = 1'b0;
`endif

    assign bus.data      = r_data;
    assign bus.valid     = r_valid;
    assign bus.overrun   = r_overrun;
    assign bus.frame_err = r_frame_err;
    assign bus.bussy     = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= bus.rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_s0    <= 1'b1;
            r_s1    <= 1'b1;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_s0    <= w_s0_nx;
            r_s1    <= w_s1_nx;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= w_par_bad_nx;
`endif
        end
    end

    // The decision tick supplies the third vote live from r_rx_s.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_s0_nx    = r_s0;
        w_s1_nx    = r_s1;
        w_good     = 1'b0;
        w_ferr     = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nx = r_par_bad;
`endif
        w_dec     = bus.tick && (r_cnt == C_DEC);
        w_last    = bus.tick && (r_cnt == C_LAST);
        w_maj     = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);
        w_cnt_inc = w_last ? '0 : r_cnt + 1'b1;
        if (bus.tick && r_cnt == C_S0) w_s0_nx = r_rx_s;
        if (bus.tick && r_cnt == C_S1) w_s1_nx = r_rx_s;
        if (bus.tick) begin
            case (r_state)
                IDLE: begin
                    // The detecting tick is count 0, so START resumes at 1.
                    if (!r_rx_s) begin
                        w_state_nx = START;
                        w_cnt_nx   = CW'(1);
                    end
                end
                START: begin
                    w_cnt_nx = w_cnt_inc;
                    if (w_dec && w_maj) begin
                        w_state_nx = IDLE;
                        w_cnt_nx   = '0;
                    end else if (w_last) begin
                        w_state_nx = DATA;
                        w_bit_nx   = '0;
                    end
                end
                DATA: begin
                    w_cnt_nx = w_cnt_inc;
                    if (w_dec) w_shift_nx = {w_maj, r_shift[7:1]};
                    if (w_last) begin
                        w_bit_nx = r_bit + 1'b1;
`ifdef UART_RX_PARITY_EN
                        if (r_bit == 3'd7) w_state_nx = PARITY;
`else
                        if (r_bit == 3'd7) w_state_nx = STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    w_cnt_nx = w_cnt_inc;
                    if (w_dec) w_par_bad_nx = w_maj ^ (^r_shift);
                    if (w_last) w_state_nx = STOP;
                end
`endif
                STOP: begin
                    w_cnt_nx = w_cnt_inc;
                    if (w_dec) begin
                        w_cnt_nx = '0;
                        if (w_maj) begin
                            w_state_nx = IDLE;
                            w_good     = !w_par_bad;
                            w_ferr     = w_par_bad;
                        end else begin
                            w_state_nx = BRK_WAIT;
                            w_ferr     = 1'b1;
                        end
                    end
                end
                BRK_WAIT: begin
                    if (r_rx_s) w_state_nx = IDLE;
                end
                default: begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            if (r_valid && bus.ready) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
            if (w_good) begin
                if (!r_valid || bus.ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end
endmodule
